// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply controller.
// Contents: state encoding, word/product widths, settle counter width.
// Optional feature macro used elsewhere in this block: MUL_OVF_EN.
package mul_pkg;
  localparam int WORD_W = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    DONE   = 2'b10
  } state_t;
endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// Bus bundle between the datapath control unit (master), the controller
// (slave) and the combinational Booth multiplier.
// Signals: start/busy/done handshake, op_a/op_b operand sources,
// mul_a/mul_b registered operands, mul_c product, hi_*/lo_* direct
// write ports, hi_out/lo_out registers, ovf (only with MUL_OVF_EN).
interface mul_hilo_ctrl_if;
  import mul_pkg::*;

  logic              start;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] mul_a;
  logic [WORD_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_c;
  logic [WORD_W-1:0] hi_in;
  logic [WORD_W-1:0] lo_in;
  logic              hi_we;
  logic              lo_we;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] hi_out;
  logic [WORD_W-1:0] lo_out;
`ifdef MUL_OVF_EN
  logic              ovf;
`endif

  modport master (
    output start, op_a, op_b, mul_c, hi_in, lo_in, hi_we, lo_we,
`ifdef MUL_OVF_EN
    input  ovf,
`endif
    input  mul_a, mul_b, busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op_a, op_b, mul_c, hi_in, lo_in, hi_we, lo_we,
`ifdef MUL_OVF_EN
    output ovf,
`endif
    output mul_a, mul_b, busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/mul_hilo_ctrl_hilo_reg.sv
// hilo_reg: one 32-bit HI or LO register.
// Ports: clk, clr (async, active-high), cap_en/cap_d (product capture),
// wr_en/wr_d (direct write), q (register value).
// Product capture outranks a simultaneous direct write.
module hilo_reg
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              cap_en,
  input  logic [WORD_W-1:0] cap_d,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_d,
  output logic [WORD_W-1:0] q
);
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         q <= '0;
    else if (cap_en) q <= cap_d;
    else if (wr_en)  q <= wr_d;
  end
endmodule

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: latches operands for the Booth multiplier, holds them for
// SETTLE_CYCLES (1..15) and then captures the 64-bit product into HI/LO.
// Ports: clk, clr (async, active-high), bus (mul_hilo_ctrl_if.slave).
// Optional: define MUL_OVF_EN to add the ovf flag (signed product does not
// fit in 32 bits).
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | operands held, counting down the multicycle path
// DONE   | HI/LO hold the new product; start accepted again
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             clr,
  mul_hilo_ctrl_if.slave   bus
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] a_q, b_q;
  logic              load_ops;
  logic              capture;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_ops) begin
        a_q <= bus.op_a;
        b_q <= bus.op_b;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_ops = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          load_ops = 1'b1;
          cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
          state_d  = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mul_a = a_q;
  assign bus.mul_b = b_q;
  assign bus.busy  = (state_q == SETTLE);
  assign bus.done  = (state_q == DONE);

  hilo_reg u_hi (
    .clk    (clk),
    .clr    (clr),
    .cap_en (capture),
    .cap_d  (bus.mul_c[PROD_W-1:WORD_W]),
    .wr_en  (bus.hi_we),
    .wr_d   (bus.hi_in),
    .q      (bus.hi_out)
  );

  hilo_reg u_lo (
    .clk    (clk),
    .clr    (clr),
    .cap_en (capture),
    .cap_d  (bus.mul_c[WORD_W-1:0]),
    .wr_en  (bus.lo_we),
    .wr_d   (bus.lo_in),
    .q      (bus.lo_out)
  );

`ifdef MUL_OVF_EN
  logic ovf_q;

  // Overflow when the upper word is not a pure sign extension of the lower.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          ovf_q <= 1'b0;
    else if (capture) ovf_q <= (bus.mul_c[PROD_W-1:WORD_W] != {WORD_W{bus.mul_c[WORD_W-1]}});
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
module tb_mul_hilo_ctrl;
  logic clk;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_hilo_ctrl_if bus0 ();
  mul_hilo_ctrl_if bus1 ();

  mul_hilo_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus0.slave)
  );

  mul_hilo_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk (clk),
    .clr (clr),
    .bus (bus1.slave)
  );

  // Signed Booth multiplier models
  assign bus0.mul_c = $signed({{32{bus0.mul_a[31]}}, bus0.mul_a}) *
                      $signed({{32{bus0.mul_b[31]}}, bus0.mul_b});
  assign bus1.mul_c = $signed({{32{bus1.mul_a[31]}}, bus1.mul_a}) *
                      $signed({{32{bus1.mul_b[31]}}, bus1.mul_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];
  vec_t fast [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[5] = '{32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1};

    fast[0] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0023, 1'b0};
    fast[1] = '{32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    fast[2] = '{32'h4000_0000, 32'h0000_0004, 32'h0000_0001, 32'h0000_0000, 1'b1};
    fast[3] = '{32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h1234_5678, 1'b0};

    clr = 1'b1;
    bus0.start = 1'b0; bus0.op_a = '0; bus0.op_b = '0;
    bus0.hi_in = '0; bus0.lo_in = '0; bus0.hi_we = 1'b0; bus0.lo_we = 1'b0;
    bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
    bus1.hi_in = '0; bus1.lo_in = '0; bus1.hi_we = 1'b0; bus1.lo_we = 1'b0;

    // reset state
    #2;
    chk("rst_busy",  64'(bus0.busy),   64'd0);
    chk("rst_done",  64'(bus0.done),   64'd0);
    chk("rst_mul_a", 64'(bus0.mul_a),  64'd0);
    chk("rst_mul_b", 64'(bus0.mul_b),  64'd0);
    chk("rst_hi",    64'(bus0.hi_out), 64'd0);
    chk("rst_lo",    64'(bus0.lo_out), 64'd0);
`ifdef MUL_OVF_EN
    chk("rst_ovf",   64'(bus0.ovf),    64'd0);
`endif
    @(negedge clk);
    clr = 1'b0;
    tick();

    // table-driven multiplies, SETTLE_CYCLES=2
    for (int i = 0; i < 7; i++) begin
      bus0.op_a = vecs[i].a;
      bus0.op_b = vecs[i].b;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      chk($sformatf("v%0d_c1_busy", i), 64'(bus0.busy), 64'd1);
      chk($sformatf("v%0d_c1_done", i), 64'(bus0.done), 64'd0);
      chk($sformatf("v%0d_mul_a", i), 64'(bus0.mul_a), 64'(vecs[i].a));
      chk($sformatf("v%0d_mul_b", i), 64'(bus0.mul_b), 64'(vecs[i].b));
      tick();
      chk($sformatf("v%0d_c2_busy", i), 64'(bus0.busy), 64'd1);
      chk($sformatf("v%0d_c2_done", i), 64'(bus0.done), 64'd0);
      tick();
      chk($sformatf("v%0d_c3_done", i), 64'(bus0.done), 64'd1);
      chk($sformatf("v%0d_c3_busy", i), 64'(bus0.busy), 64'd0);
      chk($sformatf("v%0d_hi", i), 64'(bus0.hi_out), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(bus0.lo_out), 64'(vecs[i].lo));
`ifdef MUL_OVF_EN
      chk($sformatf("v%0d_ovf", i), 64'(bus0.ovf), 64'(vecs[i].ovf));
`endif
      tick();
      chk($sformatf("v%0d_c4_done", i), 64'(bus0.done), 64'd0);
    end

    // direct writes in IDLE; ovf from last vector (1) must survive
    bus0.hi_in = 32'h1234_5678; bus0.hi_we = 1'b1;
    tick();
    bus0.hi_we = 1'b0;
    chk("dw_hi", 64'(bus0.hi_out), 64'h1234_5678);
    chk("dw_lo_untouched", 64'(bus0.lo_out), 64'hFFFF_FFFE);
    bus0.lo_in = 32'hCAFE_F00D; bus0.lo_we = 1'b1;
    tick();
    bus0.lo_we = 1'b0;
    chk("dw_lo", 64'(bus0.lo_out), 64'hCAFE_F00D);
    chk("dw_hi_kept", 64'(bus0.hi_out), 64'h1234_5678);
`ifdef MUL_OVF_EN
    chk("dw_ovf_kept", 64'(bus0.ovf), 64'd1);
`endif

    // start while busy is ignored
    bus0.op_a = 32'h0000_0003; bus0.op_b = 32'hFFFF_FFFB; bus0.start = 1'b1;
    tick();
    bus0.op_a = 32'h0000_0064; bus0.op_b = 32'h0000_0064; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    chk("ign_mul_a", 64'(bus0.mul_a), 64'h0000_0003);
    chk("ign_mul_b", 64'(bus0.mul_b), 64'hFFFF_FFFB);
    chk("ign_busy",  64'(bus0.busy),  64'd1);
    tick();
    chk("ign_done", 64'(bus0.done),   64'd1);
    chk("ign_hi",   64'(bus0.hi_out), 64'hFFFF_FFFF);
    chk("ign_lo",   64'(bus0.lo_out), 64'hFFFF_FFF1);
    tick();
    chk("ign_idle", 64'(bus0.busy),   64'd0);

    // direct write mid-SETTLE lands, direct write on capture edge is lost
    bus0.op_a = 32'h0000_0003; bus0.op_b = 32'hFFFF_FFFB; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.hi_in = 32'hAAAA_5555; bus0.hi_we = 1'b1;
    tick();
    chk("col_settle_wr", 64'(bus0.hi_out), 64'hAAAA_5555);
    bus0.hi_in = 32'hDEAD_BEEF; bus0.lo_in = 32'h1111_1111; bus0.lo_we = 1'b1;
    tick();
    bus0.hi_we = 1'b0; bus0.lo_we = 1'b0;
    chk("col_done", 64'(bus0.done),   64'd1);
    chk("col_hi",   64'(bus0.hi_out), 64'hFFFF_FFFF);
    chk("col_lo",   64'(bus0.lo_out), 64'hFFFF_FFF1);
    tick();

    // clr mid-SETTLE discards the multiply
    bus0.op_a = 32'h0000_0007; bus0.op_b = 32'h0000_0006; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr_busy",  64'(bus0.busy),   64'd0);
    chk("clr_done",  64'(bus0.done),   64'd0);
    chk("clr_mul_a", 64'(bus0.mul_a),  64'd0);
    chk("clr_mul_b", 64'(bus0.mul_b),  64'd0);
    chk("clr_hi",    64'(bus0.hi_out), 64'd0);
    chk("clr_lo",    64'(bus0.lo_out), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("clr_after%0d_done", k), 64'(bus0.done), 64'd0);
      chk($sformatf("clr_after%0d_hilo", k), {bus0.hi_out, bus0.lo_out}, 64'd0);
    end

    // SETTLE_CYCLES=1 with start held high: one result every 2 cycles
    bus1.op_a = fast[0].a; bus1.op_b = fast[0].b; bus1.start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("f%0d_busy", k), 64'(bus1.busy), 64'd1);
      chk($sformatf("f%0d_nodone", k), 64'(bus1.done), 64'd0);
      tick();
      chk($sformatf("f%0d_done", k), 64'(bus1.done), 64'd1);
      chk($sformatf("f%0d_hi", k), 64'(bus1.hi_out), 64'(fast[k].hi));
      chk($sformatf("f%0d_lo", k), 64'(bus1.lo_out), 64'(fast[k].lo));
`ifdef MUL_OVF_EN
      chk($sformatf("f%0d_ovf", k), 64'(bus1.ovf), 64'(fast[k].ovf));
`endif
      if (k < 3) begin
        bus1.op_a = fast[k+1].a;
        bus1.op_b = fast[k+1].b;
      end else begin
        bus1.start = 1'b0;
      end
      tick();
    end
    chk("f_end_idle", 64'(bus1.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
